// File: rtl/ara_test_harness.sv
// Simulation top harness around the Ara vector SoC.
// Forwards the SoC end-of-computation word and measures kernel runtime plus
// CVA6 stall statistics over each hardware-counter enable window. Every
// window is frozen into result buffers on its falling edge.

// Backing store of the SoC memory. init_val is written only by the host
// (testbench) through a hierarchical reference and is never written here.
// Row 0 doubles as a status mailbox that the SoC model publishes.
module ara_dram #(
  parameter int unsigned AxiDataWidth = 256,
  parameter int unsigned NrWords      = 1
) (
  output logic [AxiDataWidth-1:0] mbox_o
);

  logic [AxiDataWidth-1:0] init_val [NrWords] = '{default: '0};

  assign mbox_o = init_val[0];

endmodule

// Behavioural stand-in for CVA6 + Ara + DRAM. The core status seen by the
// harness (exit word, counter enable and stall strobes) is taken from the
// DRAM mailbox row and registered once, like a real core's status CSRs.
//   [63:0] exit word, [64] hw_cnt_en, [65] dcache stall,
//   [66] icache stall, [67] scoreboard full
module ara_soc #(
  parameter int unsigned NrLanes      = 8,
  parameter int unsigned VLEN         = 256,
  parameter int unsigned AxiAddrWidth = 64,
  parameter int unsigned AxiDataWidth = 64 * NrLanes / 2,
  parameter int unsigned AxiRespDelay = 200
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic [63:0] exit_o,
  output logic [0:0]  hw_cnt_en_o,
  output logic        dcache_stall_o,
  output logic        icache_stall_o,
  output logic        sb_full_o
);

  localparam int unsigned StatusW = 68;
  localparam int unsigned EnBit   = 64;
  localparam int unsigned DstBit  = 65;
  localparam int unsigned IstBit  = 66;
  localparam int unsigned SbfBit  = 67;

  // Configuration that only matters to the real SoC (lane count, VLEN,
  // address map, AXI response delay) is carried for interface compatibility.
  localparam longint unsigned unused_cfg =
    longint'(NrLanes) + longint'(VLEN) + longint'(AxiAddrWidth) + longint'(AxiRespDelay);

  logic [AxiDataWidth-1:0] mbox;
  logic [StatusW-1:0]      status_q;
  logic                    unused_mbox;

  ara_dram #(
    .AxiDataWidth (AxiDataWidth),
    .NrWords      (1)
  ) i_dram (
    .mbox_o (mbox)
  );

  assign unused_mbox = ^mbox[AxiDataWidth-1:StatusW];

  // Core status register, refreshed every cycle from the mailbox row.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      status_q <= '0;
    end else begin
      status_q <= mbox[StatusW-1:0];
    end
  end

  assign exit_o         = status_q[63:0];
  assign hw_cnt_en_o[0] = status_q[EnBit];
  assign dcache_stall_o = status_q[DstBit];
  assign icache_stall_o = status_q[IstBit];
  assign sb_full_o      = status_q[SbfBit];

endmodule

// Harness top: exit forwarding plus windowed runtime/stall statistics.
module ara_test_harness #(
  parameter int unsigned NrLanes      = 8,
  parameter int unsigned VLEN         = 256,
  parameter int unsigned AxiAddrWidth = 64,
  parameter int unsigned AxiDataWidth = 64 * NrLanes / 2,
  parameter int unsigned AxiRespDelay = 200
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic [63:0] exit_o
);

  logic [63:0] soc_exit;
  logic [0:0]  hw_cnt_en;
  logic        dcache_stall;
  logic        icache_stall;
  logic        sb_full;

  logic        cnt_en;
  logic        en_q;
  logic        cnt_rise;
  logic        cnt_fall;

  logic [63:0] exit_q;

  logic [63:0] runtime_d;
  logic [63:0] dstall_d;
  logic [63:0] istall_d;
  logic [63:0] sbfull_d;

  logic [63:0] runtime_buf_q;
  logic [63:0] dcache_stall_buf_q;
  logic [63:0] icache_stall_buf_q;
  logic [63:0] sb_full_buf_q;

  ara_soc #(
    .NrLanes      (NrLanes),
    .VLEN         (VLEN),
    .AxiAddrWidth (AxiAddrWidth),
    .AxiDataWidth (AxiDataWidth),
    .AxiRespDelay (AxiRespDelay)
  ) i_ara_soc (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .exit_o         (soc_exit),
    .hw_cnt_en_o    (hw_cnt_en),
    .dcache_stall_o (dcache_stall),
    .icache_stall_o (icache_stall),
    .sb_full_o      (sb_full)
  );

  assign cnt_en   = hw_cnt_en[0];
  assign cnt_rise = cnt_en & ~en_q;
  assign cnt_fall = ~cnt_en & en_q;

  // ---- stage: exit capture and enable history ----

  // Exit word follows the SoC until the EOC flag is seen, then it is frozen.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      exit_q <= '0;
    end else if (!exit_q[0]) begin
      exit_q <= soc_exit;
    end
  end

  assign exit_o = exit_q;

  // One-cycle delayed enable for edge detection.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      en_q <= 1'b0;
    end else begin
      en_q <= cnt_en;
    end
  end

  // ---- stage: live counters ----

  // Cleared on the rising edge (that cycle is not counted); afterwards they
  // accumulate every cycle the enable stays high and hold while it is low.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      runtime_d <= '0;
      dstall_d  <= '0;
      istall_d  <= '0;
      sbfull_d  <= '0;
    end else if (cnt_rise) begin
      runtime_d <= '0;
      dstall_d  <= '0;
      istall_d  <= '0;
      sbfull_d  <= '0;
    end else if (cnt_en) begin
      runtime_d <= runtime_d + 64'd1;
      dstall_d  <= dstall_d + {63'd0, dcache_stall};
      istall_d  <= istall_d + {63'd0, icache_stall};
      sbfull_d  <= sbfull_d + {63'd0, sb_full};
    end
  end

  // ---- stage: result buffers ----

  // Snapshot of the live counters on each falling edge of the enable.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      runtime_buf_q      <= '0;
      dcache_stall_buf_q <= '0;
      icache_stall_buf_q <= '0;
      sb_full_buf_q      <= '0;
    end else if (cnt_fall) begin
      runtime_buf_q      <= runtime_d;
      dcache_stall_buf_q <= dstall_d;
      icache_stall_buf_q <= istall_d;
      sb_full_buf_q      <= sbfull_d;
    end
  end

endmodule

// File: tb/tb_ara_test_harness.sv
// Scoreboard bench for ara_test_harness: stimulus drives the SoC status
// mailbox in DRAM row 0 and queues expected results; a monitor checks them.
module tb_ara_test_harness;

  localparam int unsigned W = 256;

  localparam int K_BUF  = 0;
  localparam int K_EXIT = 1;
  localparam int K_ZERO = 2;

  typedef struct {
    int          kind;
    int          due;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] c;
    logic [63:0] d;
  } item_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] exit_o;

  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  item_t       sb[$];

  logic [63:0] soc_ex;
  bit          soc_en;

  logic [63:0] exp_exit;
  logic [63:0] exp_rt, exp_ds, exp_is, exp_ss;

  ara_test_harness dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .exit_o (exit_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time exceeded, pending=%0d", sb.size());
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got 0x%h, expected 0x%h", name, cyc, act, exp);
    end
  endtask

  // Monitor: compares every queued expectation in the cycle it becomes due.
  always @(negedge clk) begin : monitor
    item_t it;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      it = sb.pop_front();
      if (it.due < cyc) begin
        n_tests++;
        n_fail++;
        $display("FAIL missed_check: due cyc %0d, now %0d", it.due, cyc);
      end else if (it.kind == K_BUF) begin
        chk("runtime_buf",      dut.runtime_buf_q,      it.a);
        chk("dcache_stall_buf", dut.dcache_stall_buf_q, it.b);
        chk("icache_stall_buf", dut.icache_stall_buf_q, it.c);
        chk("sb_full_buf",      dut.sb_full_buf_q,      it.d);
      end else if (it.kind == K_EXIT) begin
        chk("exit_o", exit_o, it.a);
      end else begin
        chk("reset_exit_o",       exit_o,                 64'd0);
        chk("reset_runtime_buf",  dut.runtime_buf_q,      64'd0);
        chk("reset_dstall_buf",   dut.dcache_stall_buf_q, 64'd0);
        chk("reset_istall_buf",   dut.icache_stall_buf_q, 64'd0);
        chk("reset_sbfull_buf",   dut.sb_full_buf_q,      64'd0);
        chk("reset_runtime_live", dut.runtime_d,          64'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int kind, input int due, input logic [63:0] a,
                      input logic [63:0] b, input logic [63:0] c, input logic [63:0] d);
    item_t it;
    it.kind = kind;
    it.due  = due;
    it.a    = a;
    it.b    = b;
    it.c    = c;
    it.d    = d;
    sb.push_back(it);
  endtask

  // Publish the SoC status for the coming cycle through the DRAM mailbox row.
  task automatic put(input bit d, input bit i, input bit s);
    logic [W-1:0] r;
    r       = '0;
    r[63:0] = soc_ex;
    r[64]   = soc_en;
    r[65]   = d;
    r[66]   = i;
    r[67]   = s;
    dut.i_ara_soc.i_dram.init_val[0] = r;
  endtask

  // Enable window of n cycles. Expected stall counts are the number of
  // strobes raised during the window excluding its first cycle; runtime is n-1.
  // mode 1: dcache stall in the first 31 cycles, icache in the first 6.
  task automatic window(input int n, input int mode, input int eoc_at, input logic [63:0] eoc_val);
    int ds, is, ss;
    bit d, i, s;
    ds = 0;
    is = 0;
    ss = 0;
    for (int k = 0; k < n; k++) begin
      if (mode == 1) begin
        d = (k <= 30);
        i = (k <= 5);
        s = 1'b0;
      end else begin
        d = 1'($urandom_range(0, 1));
        i = 1'($urandom_range(0, 1));
        s = 1'($urandom_range(0, 1));
      end
      if (k > 0) begin
        ds += int'(d);
        is += int'(i);
        ss += int'(s);
      end
      if (k == eoc_at) soc_ex = eoc_val;
      soc_en = 1'b1;
      put(d, i, s);
      if (k == eoc_at) begin
        if (!exp_exit[0]) exp_exit = eoc_val;
        push(K_EXIT, cyc + 2, exp_exit, 64'd0, 64'd0, 64'd0);
        push(K_BUF, cyc + 2, exp_rt, exp_ds, exp_is, exp_ss);
      end
      tick();
    end
    soc_en = 1'b0;
    put(1'b0, 1'b0, 1'b0);
    exp_rt = 64'(n - 1);
    exp_ds = 64'(ds);
    exp_is = 64'(is);
    exp_ss = 64'(ss);
    push(K_BUF, cyc + 2, exp_rt, exp_ds, exp_is, exp_ss);
    repeat (3 + $urandom_range(0, 3)) tick();
  endtask

  task automatic set_exit(input logic [63:0] v);
    soc_ex = v;
    put(1'b0, 1'b0, 1'b0);
    if (!exp_exit[0]) exp_exit = v;
    push(K_EXIT, cyc + 2, exp_exit, 64'd0, 64'd0, 64'd0);
    repeat (3) tick();
  endtask

  task automatic reset_mid_window();
    soc_ex = 64'd0;
    soc_en = 1'b1;
    put(1'b0, 1'b1, 1'b0);
    repeat (5) tick();
    rst_n    = 1'b0;
    exp_exit = 64'd0;
    exp_rt   = 64'd0;
    exp_ds   = 64'd0;
    exp_is   = 64'd0;
    exp_ss   = 64'd0;
    push(K_ZERO, cyc, 64'd0, 64'd0, 64'd0, 64'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    window(10, 0, -1, 64'd0);
  endtask

  initial begin
    soc_ex   = 64'd0;
    soc_en   = 1'b0;
    exp_exit = 64'd0;
    exp_rt   = 64'd0;
    exp_ds   = 64'd0;
    exp_is   = 64'd0;
    exp_ss   = 64'd0;
    put(1'b0, 1'b0, 1'b0);

    repeat (10) tick();
    push(K_ZERO, cyc, 64'd0, 64'd0, 64'd0, 64'd0);
    tick();
    rst_n = 1'b1;
    push(K_EXIT, cyc + 2, 64'd0, 64'd0, 64'd0, 64'd0);
    repeat (3) tick();

    window(101, 1, -1, 64'd0);
    window(50, 0, -1, 64'd0);
    window(20, 0, -1, 64'd0);
    repeat (6) window(int'($urandom_range(2, 40)), 0, -1, 64'd0);

    set_exit(64'h4);
    window(30, 0, 12, 64'h7);
    set_exit(64'h0);
    set_exit(64'h1);

    reset_mid_window();

    set_exit(64'h1);
    set_exit(64'h0);
    set_exit(64'h6);

    for (int t = 0; t < 20 && sb.size() > 0; t++) tick();
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d checks still pending, expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
